// File: rtl/instr_sequencer.sv
// Fetch/dispatch controller: walks the PC through instruction memory, latches each
// instruction's fields and hands it to the matrix or integer ALU with a go/done handshake.
module instr_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         Start,
    output logic [15:0]  address,
    output logic         nRead,
    input  logic [255:0] InstructDataIn,
    output logic [7:0]   Opcode,
    output logic [7:0]   Dest,
    output logic [7:0]   Src1,
    output logic [7:0]   Src2,
    output logic         MatrixGo,
    output logic         IntGo,
    input  logic         MatrixDone,
    input  logic         IntDone,
    output logic [3:0]   PC,
    output logic         Busy,
    output logic         Halted,
    output logic         IllegalOp,
    output logic         Timeout
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [3:0] LAST_PC = 4'(PROG_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        DISPATCH,
        EXEC,
        HALT
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      pc_q, pc_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            unitInt_q, unitInt_d;
    logic [7:0]      opcode_q, opcode_d, dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
    logic [15:0]     address_q, address_d;
    logic            nRead_q, nRead_d;
    logic            matrixGo_q, matrixGo_d, intGo_q, intGo_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d, illegal_q, illegal_d, timeout_q, timeout_d;
    logic            done;
    logic            unusedData;

    // Only the low instruction word of the wide memory bus is meaningful.
    assign unusedData = ^InstructDataIn[255:32];

    function automatic logic isMatrix(input logic [7:0] op);
        return op <= 8'h05;
    endfunction

    function automatic logic isInt(input logic [7:0] op);
        return (op >= 8'h10) && (op <= 8'h13);
    endfunction

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q    <= IDLE;
            pc_q       <= 4'd0;
            wd_q       <= '0;
            unitInt_q  <= 1'b0;
            opcode_q   <= 8'h00;
            dest_q     <= 8'h00;
            src1_q     <= 8'h00;
            src2_q     <= 8'h00;
            address_q  <= 16'h0000;
            nRead_q    <= 1'b1;
            matrixGo_q <= 1'b0;
            intGo_q    <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wd_q       <= wd_d;
            unitInt_q  <= unitInt_d;
            opcode_q   <= opcode_d;
            dest_q     <= dest_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            address_q  <= address_d;
            nRead_q    <= nRead_d;
            matrixGo_q <= matrixGo_d;
            intGo_q    <= intGo_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Go pulses are decoded straight from the memory word while leaving LOAD, so
    // they are registered and line up with the DISPATCH cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wd_d       = wd_q;
        unitInt_d  = unitInt_q;
        opcode_d   = opcode_q;
        dest_d     = dest_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        matrixGo_d = 1'b0;
        intGo_d    = 1'b0;
        done       = unitInt_q ? IntDone : MatrixDone;

        case (state_q)
            IDLE, HALT: begin
                if (Start) begin
                    state_d   = FETCH;
                    pc_d      = 4'd0;
                    halted_d  = 1'b0;
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                state_d    = DISPATCH;
                opcode_d   = InstructDataIn[31:24];
                dest_d     = InstructDataIn[23:16];
                src1_d     = InstructDataIn[15:8];
                src2_d     = InstructDataIn[7:0];
                matrixGo_d = isMatrix(InstructDataIn[31:24]);
                intGo_d    = isInt(InstructDataIn[31:24]);
            end
            DISPATCH: begin
                if (isMatrix(opcode_q) || isInt(opcode_q)) begin
                    state_d   = EXEC;
                    wd_d      = WD_W'(TIMEOUT);
                    unitInt_d = isInt(opcode_q);
                end else begin
                    state_d   = HALT;
                    halted_d  = 1'b1;
                    illegal_d = (opcode_q != 8'hFF);
                end
            end
            EXEC: begin
                if (done) begin
                    if (pc_q == LAST_PC) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d    = pc_q + 4'd1;
                        state_d = FETCH;
                    end
                end else if (wd_q == '0) begin
                    state_d   = HALT;
                    halted_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        address_d = (state_d == FETCH) ? {4'h2, 8'h00, pc_d} : 16'h0000;
        nRead_d   = (state_d != FETCH);
        busy_d    = (state_d != IDLE) && (state_d != HALT);
    end

    assign address   = address_q;
    assign nRead     = nRead_q;
    assign Opcode    = opcode_q;
    assign Dest      = dest_q;
    assign Src1      = src1_q;
    assign Src2      = src2_q;
    assign MatrixGo  = matrixGo_q;
    assign IntGo     = intGo_q;
    assign PC        = pc_q;
    assign Busy      = busy_q;
    assign Halted    = halted_q;
    assign IllegalOp = illegal_q;
    assign Timeout   = timeout_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: instance A (16 words, TIMEOUT 8) for the main
// scenarios, instance B (4 words) for the end-of-memory halt.
module tb_instr_sequencer;

    logic         Clk = 1'b0;
    logic         nReset = 1'b0;
    logic         startA = 1'b0, startB = 1'b0;
    logic [31:0]  mem [0:15];
    logic [255:0] dataA = '0, dataB = '0;
    logic         aluEn = 1'b0, forceIntDoneA = 1'b0;
    logic [1:0]   mPipeA = '0, iPipeA = '0, mPipeB = '0, iPipeB = '0;

    logic [15:0] addrA, addrB;
    logic        nReadA, nReadB, mGoA, iGoA, mGoB, iGoB;
    logic [7:0]  opA, destA, src1A, src2A, opB, destB, src1B, src2B;
    logic [3:0]  pcA, pcB;
    logic        busyA, haltA, illA, toA, busyB, haltB, illB, toB;
    logic        mDoneA, iDoneA, mDoneB, iDoneB;

    int errors = 0;
    int checks = 0;
    logic [8:0] goLog [$];
    int fetchB = 0;
    int goHighB = 0;

    localparam logic [58:0] RESET_SNAP = {16'h0000, 1'b1, 32'h0, 2'b00, 4'h0, 4'b0000};

    always #5 Clk = ~Clk;

    instr_sequencer #(.PROG_DEPTH(16), .TIMEOUT(8)) dutA (
        .Clk(Clk), .nReset(nReset), .Start(startA), .address(addrA), .nRead(nReadA),
        .InstructDataIn(dataA), .Opcode(opA), .Dest(destA), .Src1(src1A), .Src2(src2A),
        .MatrixGo(mGoA), .IntGo(iGoA), .MatrixDone(mDoneA), .IntDone(iDoneA), .PC(pcA),
        .Busy(busyA), .Halted(haltA), .IllegalOp(illA), .Timeout(toA)
    );

    instr_sequencer #(.PROG_DEPTH(4), .TIMEOUT(8)) dutB (
        .Clk(Clk), .nReset(nReset), .Start(startB), .address(addrB), .nRead(nReadB),
        .InstructDataIn(dataB), .Opcode(opB), .Dest(destB), .Src1(src1B), .Src2(src2B),
        .MatrixGo(mGoB), .IntGo(iGoB), .MatrixDone(mDoneB), .IntDone(iDoneB), .PC(pcB),
        .Busy(busyB), .Halted(haltB), .IllegalOp(illB), .Timeout(toB)
    );

    // Registered instruction memory and ALUs that answer Done two cycles after Go.
    assign mDoneA = aluEn & mPipeA[1];
    assign iDoneA = (aluEn & iPipeA[1]) | forceIntDoneA;
    assign mDoneB = aluEn & mPipeB[1];
    assign iDoneB = aluEn & iPipeB[1];

    always @(posedge Clk) begin
        if (!nReadA) dataA <= {{7{32'hDEADBEEF}}, mem[addrA[3:0]]};
        if (!nReadB) dataB <= {{7{32'hDEADBEEF}}, mem[addrB[3:0]]};
        mPipeA <= {mPipeA[0], mGoA};
        iPipeA <= {iPipeA[0], iGoA};
        mPipeB <= {mPipeB[0], mGoB};
        iPipeB <= {iPipeB[0], iGoB};
    end

    always @(negedge Clk) begin
        if (mGoA) goLog.push_back({1'b0, opA});
        if (iGoA) goLog.push_back({1'b1, opA});
        if (!nReadB) fetchB++;
        if (mGoB || iGoB) goHighB++;
    end

    function automatic logic [58:0] snapA();
        return {addrA, nReadA, opA, destA, src1A, src2A, mGoA, iGoA, pcA, busyA, haltA, illA, toA};
    endfunction

    function automatic logic [58:0] snapB();
        return {addrB, nReadB, opB, destB, src1B, src2B, mGoB, iGoB, pcB, busyB, haltB, illB, toB};
    endfunction

    // Pulse Start for one cycle; returns in cycle 1 (the FETCH cycle).
    task automatic applyStimulus(input bit toB);
        if (toB) startB = 1'b1; else startA = 1'b1;
        @(negedge Clk);
        startA = 1'b0;
        startB = 1'b0;
    endtask

    task automatic test_reset;
        nReset = 1'b0;
        repeat (3) @(negedge Clk);
        checks++; if (snapA() !== RESET_SNAP) begin errors++; $display("[TB] FAIL reset_A: got %h expected %h", snapA(), RESET_SNAP); end
        checks++; if (snapB() !== RESET_SNAP) begin errors++; $display("[TB] FAIL reset_B: got %h expected %h", snapB(), RESET_SNAP); end
        nReset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_program;
        logic [8:0] expLog [9] = '{9'h001, 9'h110, 9'h002, 9'h003, 9'h111, 9'h004, 9'h112, 9'h005, 9'h000};
        bit seen = 0;
        bit logBad = 0;
        mem[0] = 32'h01020001; mem[1] = 32'h10100908; mem[2] = 32'h02030405;
        mem[3] = 32'h03000102; mem[4] = 32'h11050607; mem[5] = 32'h04010203;
        mem[6] = 32'h120A0100; mem[7] = 32'h05020304; mem[8] = 32'h00010203;
        mem[9] = 32'hFF000000;
        aluEn = 1'b1;
        goLog.delete();
        applyStimulus(0);
        checks++; if (addrA !== 16'h2000) begin errors++; $display("[TB] FAIL prog_first_addr: got %h expected 2000", addrA); end
        checks++; if (nReadA !== 1'b0) begin errors++; $display("[TB] FAIL prog_first_nread: got %b expected 0", nReadA); end
        for (int n = 0; n < 300 && !haltA; n++) begin
            @(negedge Clk);
            if (!seen && !nReadA && addrA == 16'h2006) begin
                seen = 1;
                @(negedge Clk);
                checks++; if (opA !== 8'h04) begin errors++; $display("[TB] FAIL field_load_old: got %h expected 04", opA); end
                @(negedge Clk);
                checks++; if ({opA, destA, src1A, src2A, iGoA} !== {32'h120A0100, 1'b1}) begin errors++; $display("[TB] FAIL field_dispatch: got %h expected %h", {opA, destA, src1A, src2A, iGoA}, {32'h120A0100, 1'b1}); end
                repeat (2) @(negedge Clk);
                checks++; if ({opA, destA, src1A, src2A} !== 32'h120A0100) begin errors++; $display("[TB] FAIL field_exec: got %h expected 120a0100", {opA, destA, src1A, src2A}); end
                @(negedge Clk);
                checks++; if (addrA !== 16'h2007 || {opA, destA, src1A, src2A} !== 32'h120A0100) begin errors++; $display("[TB] FAIL field_next_fetch: got addr %h fields %h expected 2007 120a0100", addrA, {opA, destA, src1A, src2A}); end
                repeat (2) @(negedge Clk);
                checks++; if ({opA, destA, src1A, src2A, mGoA} !== {32'h05020304, 1'b1}) begin errors++; $display("[TB] FAIL field_next_dispatch: got %h expected %h", {opA, destA, src1A, src2A, mGoA}, {32'h05020304, 1'b1}); end
            end
        end
        repeat (2) @(negedge Clk);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL field_fetch_2006: got none expected fetch at 2006"); end
        checks++; if ({haltA, illA, toA, busyA} !== 4'b1000) begin errors++; $display("[TB] FAIL prog_flags: got %b expected 1000", {haltA, illA, toA, busyA}); end
        checks++; if (pcA !== 4'd9) begin errors++; $display("[TB] FAIL prog_pc: got %0d expected 9", pcA); end
        checks++; if (goLog.size() !== 9) begin errors++; $display("[TB] FAIL prog_go_count: got %0d expected 9", goLog.size()); end
        for (int i = 0; i < 9 && i < goLog.size(); i++) if (goLog[i] !== expLog[i]) logBad = 1;
        checks++; if (logBad) begin errors++; $display("[TB] FAIL prog_go_order: got %p expected %p", goLog, expLog); end
    endtask

    task automatic test_illegal;
        mem[0] = 32'h07000000;
        goLog.delete();
        applyStimulus(0);
        checks++; if ({haltA, pcA, addrA, nReadA} !== {1'b0, 4'd0, 16'h2000, 1'b0}) begin errors++; $display("[TB] FAIL restart_from_halt: got %h expected %h", {haltA, pcA, addrA, nReadA}, {1'b0, 4'd0, 16'h2000, 1'b0}); end
        repeat (2) @(negedge Clk);
        checks++; if ({mGoA, iGoA, haltA, busyA} !== 4'b0001) begin errors++; $display("[TB] FAIL illegal_dispatch: got %b expected 0001", {mGoA, iGoA, haltA, busyA}); end
        @(negedge Clk);
        checks++; if ({haltA, illA, toA, busyA} !== 4'b1100) begin errors++; $display("[TB] FAIL illegal_halt: got %b expected 1100", {haltA, illA, toA, busyA}); end
        checks++; if (opA !== 8'h07) begin errors++; $display("[TB] FAIL illegal_opcode: got %h expected 07", opA); end
        checks++; if (goLog.size() !== 0) begin errors++; $display("[TB] FAIL illegal_no_go: got %0d expected 0", goLog.size()); end
    endtask

    task automatic test_watchdog;
        bit earlyBad = 0;
        mem[0] = 32'h01000000;
        aluEn = 1'b0;
        applyStimulus(0);
        checks++; if ({haltA, illA} !== 2'b00) begin errors++; $display("[TB] FAIL wd_flags_cleared: got %b expected 00", {haltA, illA}); end
        repeat (2) @(negedge Clk);
        checks++; if (mGoA !== 1'b1) begin errors++; $display("[TB] FAIL wd_go: got %b expected 1", mGoA); end
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clk);
            forceIntDoneA = k[0];
            if (toA !== 1'b0 || haltA !== 1'b0 || busyA !== 1'b1) earlyBad = 1;
        end
        @(negedge Clk);
        forceIntDoneA = 1'b0;
        checks++; if (earlyBad) begin errors++; $display("[TB] FAIL wd_early: got early halt expected 9 busy EXEC cycles"); end
        checks++; if ({toA, haltA, illA, busyA, pcA} !== {4'b1100, 4'd0}) begin errors++; $display("[TB] FAIL wd_timeout: got %h expected %h", {toA, haltA, illA, busyA, pcA}, {4'b1100, 4'd0}); end
    endtask

    task automatic test_restart;
        mem[0] = 32'hFF000000;
        applyStimulus(0);
        checks++; if ({toA, haltA, busyA, addrA} !== {3'b001, 16'h2000}) begin errors++; $display("[TB] FAIL restart_clear: got %h expected %h", {toA, haltA, busyA, addrA}, {3'b001, 16'h2000}); end
        repeat (3) @(negedge Clk);
        checks++; if ({haltA, illA, toA, busyA} !== 4'b1000) begin errors++; $display("[TB] FAIL restart_stop: got %b expected 1000", {haltA, illA, toA, busyA}); end
    endtask

    task automatic test_reset_mid_exec;
        mem[0] = 32'h02000000;
        aluEn = 1'b0;
        applyStimulus(0);
        repeat (4) @(negedge Clk);
        checks++; if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL midexec_busy: got %b expected 1", busyA); end
        nReset = 1'b0;
        @(negedge Clk);
        goLog.delete();
        checks++; if (snapA() !== RESET_SNAP) begin errors++; $display("[TB] FAIL midexec_reset: got %h expected %h", snapA(), RESET_SNAP); end
        nReset = 1'b1;
        repeat (15) @(negedge Clk);
        checks++; if (snapA() !== RESET_SNAP || goLog.size() !== 0) begin errors++; $display("[TB] FAIL midexec_idle: got %h gos %0d expected %h gos 0", snapA(), goLog.size(), RESET_SNAP); end
    endtask

    task automatic test_end_of_memory;
        mem[0] = 32'h01000000; mem[1] = 32'h10000000; mem[2] = 32'h02000000; mem[3] = 32'h11000000;
        for (int i = 4; i < 16; i++) mem[i] = 32'h01000000;
        aluEn = 1'b1;
        fetchB = 0;
        goHighB = 0;
        applyStimulus(1);
        for (int n = 0; n < 100 && !haltB; n++) @(negedge Clk);
        repeat (10) @(negedge Clk);
        checks++; if ({haltB, illB, toB, busyB} !== 4'b1000) begin errors++; $display("[TB] FAIL eom_flags: got %b expected 1000", {haltB, illB, toB, busyB}); end
        checks++; if (pcB !== 4'd3) begin errors++; $display("[TB] FAIL eom_pc: got %0d expected 3", pcB); end
        checks++; if (fetchB !== 4) begin errors++; $display("[TB] FAIL eom_fetches: got %0d expected 4", fetchB); end
        checks++; if (goHighB !== 4) begin errors++; $display("[TB] FAIL eom_go_cycles: got %0d expected 4", goHighB); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hFF000000;
        test_reset();
        test_program();
        test_illegal();
        test_watchdog();
        test_restart();
        test_reset_mid_exec();
        test_end_of_memory();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/dispatch controller for the matrix processor. It walks the program counter through instruction memory, which sits at address enable 2. For each 32-bit instruction it latches the opcode, dest, src1 and src2 fields. It then hands the instruction to the matrix ALU (enable 3) or the integer ALU (enable 5) with a go/done handshake, and halts on the Stop opcode (FFh), an illegal opcode, end of memory, or a watchdog timeout.

## Interface
- `PROG_DEPTH`, default 16: instruction words addressable, 1..16. The PC is 4 bits.
- `TIMEOUT`, default 255: maximum cycles to wait for a Done before the watchdog halts the sequencer.
- `Clk` in 1: system clock. All logic is on the rising edge.
- `nReset` in 1: synchronous, active-low reset.
- `Start` in 1: level or pulse. Sampled only in IDLE or HALT; begins execution at PC 0.
- `address` out 16: `{4'd2, 8'd0, PC}` during FETCH, otherwise `16'h0000`.
- `nRead` out 1: low only during FETCH.
- `InstructDataIn` in 256: instruction memory output. Only bits [31:0] are used.
- `Opcode`, `Dest`, `Src1`, `Src2` out 8 each: fields of the current instruction, bits [31:24], [23:16], [15:8], [7:0].
- `MatrixGo` out 1: one-cycle pulse for opcodes 00h–05h.
- `IntGo` out 1: one-cycle pulse for opcodes 10h–13h.
- `MatrixDone`, `IntDone` in 1: completion from the matrix ALU and the integer ALU.
- `PC` out 4: address of the current instruction.
- `Busy` out 1: high in every state except IDLE and HALT.
- `Halted`, `IllegalOp`, `Timeout` out 1 each: status flags. They are sticky until Start or reset.

## Operation
- States: IDLE, FETCH, LOAD, DISPATCH, EXEC, HALT.
- **IDLE**:
  - `Start`=1 → FETCH, with PC=0 and all flags cleared.
- **FETCH** (1 cycle):
  - Drive `nRead`=0 and `address`=`{4'h2,8'h00,PC}`.
  - → LOAD.
- **LOAD** (1 cycle):
  - Instruction memory has registered its data at the end of FETCH.
  - Capture `InstructDataIn[31:0]` into the field registers at the end of this cycle.
  - → DISPATCH.
- **DISPATCH** (1 cycle): decode the latched `Opcode`.
  - 00h–05h: `MatrixGo`=1 → EXEC. Load the watchdog with `TIMEOUT`.
  - 10h–13h: `IntGo`=1 → EXEC. Load the watchdog with `TIMEOUT`.
  - FFh: no go pulse → HALT, `Halted`=1.
  - Any other value: no go pulse → HALT, `Halted`=1 and `IllegalOp`=1.
- **EXEC**:
  - Sample only the Done input that matches the dispatched unit. The other Done input is ignored.
  - On Done=1:
    - If PC=`PROG_DEPTH`-1 → HALT, `Halted`=1, and PC holds its value.
    - Otherwise PC←PC+1 → FETCH.
  - Each cycle without Done decrements the watchdog. When the watchdog is 0 and Done is still 0 → HALT, `Halted`=1 and `Timeout`=1.
  - Done takes priority over timeout in the same cycle.
- **HALT**:
  - Fields and PC hold their values.
  - `Start`=1 → FETCH, with PC=0 and flags cleared.
- `Start` is ignored in FETCH, LOAD, DISPATCH and EXEC.
- Field outputs change only at the end of LOAD. They stay stable through DISPATCH and EXEC, so the ALUs may read them at any point during execution.
- Reset mid-operation:
  - Enters IDLE at the next edge.
  - Any in-flight instruction is abandoned. No further Go pulses are issued.

## Timing
- Reset values:
  - State IDLE, `PC`=0.
  - `address`=`16'h0000`, `nRead`=1.
  - `Opcode`, `Dest`, `Src1`, `Src2` = 00h.
  - All Go outputs, `Busy` and all flags = 0.
- Every output is driven from a register. There is no combinational path from input to output.
- Cycle sequence, with `Start` sampled high at edge 0:
  - Cycle 1: FETCH.
  - Cycle 2: LOAD.
  - Cycle 3: DISPATCH. Fields are valid and the Go pulse is high.
  - Cycle 4 onward: EXEC.
- Done sampled high at edge k → FETCH of the next instruction in cycle k+1.
- Per-instruction overhead is 3 cycles plus the ALU latency. The minimum ALU latency is 1 cycle, with Done high in the first EXEC cycle.
- Stop opcode → `Halted` rises in cycle 4 after its FETCH.
- Each Go pulse is exactly 1 cycle wide. Exactly one Go pulse is issued per dispatched instruction.

## Test plan
- **Program of 10 instructions** (01020001h, 10100908h, …, FF000000h), with an ALU model returning Done 2 cycles after Go:
  - 6 `MatrixGo` and 3 `IntGo` pulses, in program order.
  - `Halted`=1 with `PC`=9, `IllegalOp`=0.
- **Field check**:
  - Word 12_0A_01_00h → `Opcode`=12h, `Dest`=0Ah, `Src1`=01h, `Src2`=00h, valid from DISPATCH until the next LOAD.
  - `address`=`16'h2006` during that instruction's FETCH.
- **Illegal opcode**: word 07_00_00_00h at PC 0 → no Go pulse, `Halted`=1 and `IllegalOp`=1 in cycle 4.
- **Watchdog**: `TIMEOUT`=8 and Done never asserted → `Timeout`=1 and `Halted`=1 exactly 9 EXEC cycles after the Go pulse.
  - `IntDone` pulsing during a matrix instruction is ignored.
- **End of memory**: `PROG_DEPTH`=4 and no Stop in the program → after the Done for PC 3, `Halted`=1, `PC`=3, and no fifth fetch.
- **Reset and restart**:
  - `nReset` low in mid-EXEC → next cycle IDLE, all outputs at reset values, no Go pulse.
  - `Start` in HALT restarts at PC 0 with flags cleared.
